// File: rtl/traffic_junction_ctrl_pkg.sv
// Shared lamp codes and sequencer state encoding for the junction controller.
package traffic_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] OFF    = 3'b000;

    typedef enum logic [2:0] {
        ST_STARTUP = 3'd0,
        ST_GREEN   = 3'd1,
        ST_YELLOW  = 3'd2,
        ST_ALLRED  = 3'd3,
        ST_FLASH   = 3'd4
    } state_e;

endpackage

// File: rtl/traffic_junction_ctrl_if.sv
// Control inputs and lamp/display outputs of the junction controller.
interface traffic_junction_ctrl_if #(
    parameter int N_DIR = 4,
    parameter int CNT_W = 4
);
    localparam int PH_W = (N_DIR > 1) ? $clog2(N_DIR) : 1;

    logic                 en;
    logic [N_DIR-1:0]     req;
    logic                 night;
    logic [3*N_DIR-1:0]   lamps;
    logic [PH_W-1:0]      phase;
    logic [CNT_W-1:0]     remain;
    logic                 tick;

    modport master (output en, req, night, input lamps, phase, remain, tick);
    modport slave  (input en, req, night, output lamps, phase, remain, tick);

endinterface

// File: rtl/traffic_junction_ctrl_tick_gen.sv
// Prescaler producing a registered one-clk tick every TICK_DIV enabled cycles.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Advance only while enabled; a frozen count at LAST wraps silently on resume
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (en) begin
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
            tick_d = (cnt_d == LAST);
        end else begin
            cnt_d  = cnt_q;
            tick_d = 1'b0;
        end
    end

    // Prescaler registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/traffic_junction_ctrl.sv
// N-way junction phase sequencer with demand skipping and night flash mode.
module traffic_junction_ctrl
    import traffic_pkg::*;
#(
    parameter int N_DIR     = 4,
    parameter int TICK_DIV  = 50_000_000,
    parameter int CNT_W     = 4,
    parameter int STARTUP_S = 2,
    parameter int GREEN_S   = 6,
    parameter int YELLOW_S  = 3,
    parameter int ALLRED_S  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    traffic_junction_ctrl_if.slave  bus
);
    localparam int PH_W    = (N_DIR > 1) ? $clog2(N_DIR) : 1;
    localparam int DUR_MAX = 1 << CNT_W;

    if (N_DIR < 2 || TICK_DIV < 2 ||
        STARTUP_S < 1 || STARTUP_S > DUR_MAX || GREEN_S < 1 || GREEN_S > DUR_MAX ||
        YELLOW_S < 1 || YELLOW_S > DUR_MAX || ALLRED_S < 1 || ALLRED_S > DUR_MAX) begin : g_bad_param
        $error("traffic_junction_ctrl: illegal parameter set");
    end

    localparam logic [CNT_W-1:0] STARTUP_LD = CNT_W'(STARTUP_S - 1);
    localparam logic [CNT_W-1:0] GREEN_LD   = CNT_W'(GREEN_S - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD  = CNT_W'(YELLOW_S - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD  = CNT_W'(ALLRED_S - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    function automatic logic [PH_W-1:0] ph_add(input logic [PH_W-1:0] p, input int unsigned k);
        logic [PH_W:0] s;
        s = {1'b0, p} + (PH_W+1)'(k);
        if (s >= (PH_W+1)'(N_DIR)) begin
            s = s - (PH_W+1)'(N_DIR);
        end else begin
            s = s;
        end
        return s[PH_W-1:0];
    endfunction

    logic                 tick_s;
    state_e               state_q, state_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [CNT_W-1:0]     remain_q, remain_d;
    logic                 flash_q, flash_d;
    logic [3*N_DIR-1:0]   lamps_q, lamps_d;
    logic [N_DIR-1:0]     req_rot_s;
    logic [PH_W-1:0]      next_ph_s;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.en),
        .tick  (tick_s)
    );

    // Bit k of the rotated request vector is the approach k places after the current phase
    always_comb begin
        req_rot_s = N_DIR'({bus.req, bus.req} >> phase_q);
        next_ph_s = req_rot_s[0] ? phase_q : ph_add(phase_q, 1);
        for (int k = N_DIR - 1; k >= 1; k--) begin
            if (req_rot_s[k]) begin
                next_ph_s = ph_add(phase_q, k);
            end else begin
                next_ph_s = next_ph_s;
            end
        end
    end

    // Interval sequencer: remain==0 at a tick ends the interval
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        remain_d = remain_q;
        flash_d  = flash_q;
        if (tick_s) begin
            case (state_q)
                ST_STARTUP: begin
                    if (remain_q == '0) begin
                        state_d  = ST_GREEN;
                        phase_d  = '0;
                        remain_d = GREEN_LD;
                    end else begin
                        remain_d = remain_q - CNT_ONE;
                    end
                end
                ST_GREEN: begin
                    if (bus.night || remain_q == '0) begin
                        state_d  = ST_YELLOW;
                        remain_d = YELLOW_LD;
                    end else begin
                        remain_d = remain_q - CNT_ONE;
                    end
                end
                ST_YELLOW: begin
                    if (remain_q == '0) begin
                        state_d  = ST_ALLRED;
                        remain_d = ALLRED_LD;
                    end else begin
                        remain_d = remain_q - CNT_ONE;
                    end
                end
                ST_ALLRED: begin
                    if (remain_q != '0) begin
                        remain_d = remain_q - CNT_ONE;
                    end else if (bus.night) begin
                        state_d  = ST_FLASH;
                        remain_d = '0;
                        flash_d  = 1'b1;
                    end else begin
                        state_d  = ST_GREEN;
                        phase_d  = next_ph_s;
                        remain_d = GREEN_LD;
                    end
                end
                ST_FLASH: begin
                    if (!bus.night) begin
                        state_d  = ST_ALLRED;
                        remain_d = ALLRED_LD;
                        flash_d  = 1'b0;
                    end else begin
                        flash_d  = ~flash_q;
                    end
                end
                default: begin
                    state_d  = ST_STARTUP;
                    phase_d  = '0;
                    remain_d = STARTUP_LD;
                    flash_d  = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Lamp decode from the next state so lamps register alongside it
    always_comb begin
        lamps_d = {N_DIR{RED}};
        for (int i = 0; i < N_DIR; i++) begin
            case (state_d)
                ST_GREEN:  lamps_d[3*i +: 3] = (phase_d == PH_W'(i)) ? GREEN : RED;
                ST_YELLOW: lamps_d[3*i +: 3] = (phase_d == PH_W'(i)) ? YELLOW : RED;
                ST_FLASH:  lamps_d[3*i +: 3] = flash_d ? YELLOW : OFF;
                default:   lamps_d[3*i +: 3] = RED;
            endcase
        end
    end

    // Sequencer and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_STARTUP;
            phase_q  <= '0;
            remain_q <= STARTUP_LD;
            flash_q  <= 1'b0;
            lamps_q  <= {N_DIR{RED}};
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            remain_q <= remain_d;
            flash_q  <= flash_d;
            lamps_q  <= lamps_d;
        end
    end

    assign bus.lamps  = lamps_q;
    assign bus.phase  = phase_q;
    assign bus.remain = remain_q;
    assign bus.tick   = tick_s;

endmodule

// File: tb/tb_traffic_junction_ctrl.sv
// Randomised scoreboard bench for traffic_junction_ctrl against a tick-level reference model.
`timescale 1ns/1ps
module tb_traffic_junction_ctrl;
    localparam int N_DIR = 4, TICK_DIV = 4, CNT_W = 4;
    localparam int STARTUP_S = 2, GREEN_S = 3, YELLOW_S = 2, ALLRED_S = 1;

    typedef enum int {M_START, M_GREEN, M_YEL, M_ALLRED, M_FLASH} mst_t;
    typedef struct { mst_t st; int phase; int left; int fidx; } mdl_t;
    typedef struct { logic [11:0] lamps; logic [1:0] phase; logic [3:0] remain; } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    traffic_junction_ctrl_if #(.N_DIR(N_DIR), .CNT_W(CNT_W)) tif ();

    traffic_junction_ctrl #(
        .N_DIR(N_DIR), .TICK_DIV(TICK_DIV), .CNT_W(CNT_W), .STARTUP_S(STARTUP_S),
        .GREEN_S(GREEN_S), .YELLOW_S(YELLOW_S), .ALLRED_S(ALLRED_S)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif.slave)
    );

    exp_t exp_q[$];
    mdl_t m;
    int   e_cnt;
    bit   tick_pend;
    exp_t cur;
    logic prev_tick;
    int   total = 0;
    int   bad = 0;
    int   to_cnt = 0;
    bit   done_req = 1'b0;

    function automatic int dur_of(input mst_t st);
        case (st)
            M_START:  return STARTUP_S;
            M_GREEN:  return GREEN_S;
            M_YEL:    return YELLOW_S;
            M_ALLRED: return ALLRED_S;
            default:  return 1;
        endcase
    endfunction

    function automatic mdl_t enter(input mst_t st, input int ph);
        mdl_t s;
        s.st = st; s.phase = ph; s.left = dur_of(st); s.fidx = 0;
        return s;
    endfunction

    // Next green: nearest requester after the current one, else current if it asks, else the next one
    function automatic int pick(input int p, input logic [3:0] r);
        for (int d = 1; d < N_DIR; d++)
            if (r[(p + d) % N_DIR]) return (p + d) % N_DIR;
        return r[p] ? p : (p + 1) % N_DIR;
    endfunction

    function automatic mdl_t step(input mdl_t cm, input logic [3:0] r, input logic n);
        mdl_t s;
        s = cm;
        case (cm.st)
            M_START:  begin s.left = cm.left - 1; if (s.left == 0) s = enter(M_GREEN, 0); end
            M_GREEN:  begin s.left = cm.left - 1; if (n || s.left == 0) s = enter(M_YEL, cm.phase); end
            M_YEL:    begin s.left = cm.left - 1; if (s.left == 0) s = enter(M_ALLRED, cm.phase); end
            M_ALLRED: begin
                s.left = cm.left - 1;
                if (s.left == 0) s = n ? enter(M_FLASH, cm.phase) : enter(M_GREEN, pick(cm.phase, r));
            end
            M_FLASH:  begin if (!n) s = enter(M_ALLRED, cm.phase); else s.fidx = cm.fidx + 1; end
            default:  s = enter(M_START, 0);
        endcase
        return s;
    endfunction

    function automatic exp_t view(input mdl_t cm);
        exp_t e;
        logic [2:0] code;
        for (int i = 0; i < N_DIR; i++) begin
            code = 3'b100;
            if (cm.st == M_GREEN && cm.phase == i) code = 3'b001;
            if (cm.st == M_YEL && cm.phase == i) code = 3'b010;
            if (cm.st == M_FLASH) code = (cm.fidx % 2 == 0) ? 3'b010 : 3'b000;
            e.lamps[3*i +: 3] = code;
        end
        e.phase  = 2'(cm.phase);
        e.remain = (cm.st == M_FLASH) ? 4'd0 : 4'(cm.left - 1);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total = total + 1;
        if (act !== expv) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference model: counts enabled cycles for ticks and steps the interval rules on each tick
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m         <= enter(M_START, 0);
            e_cnt     <= 0;
            tick_pend <= 1'b0;
            exp_q.delete();
        end else begin
            if (tick_pend) begin
                exp_q.push_back(view(step(m, tif.req, tif.night)));
                m <= step(m, tif.req, tif.night);
            end
            e_cnt     <= e_cnt + (tif.en ? 1 : 0);
            tick_pend <= tif.en ? (((e_cnt + 1) % TICK_DIV) == TICK_DIV - 1) : 1'b0;
        end
    end

    // Monitor: after each DUT tick pop the expected outputs, then compare every cycle
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            #1;
            chk("rst_lamps", 32'(tif.lamps), 32'h924);
            chk("rst_phase", 32'(tif.phase), 32'd0);
            chk("rst_remain", 32'(tif.remain), 32'd1);
            chk("rst_tick", 32'(tif.tick), 32'd0);
            cur = view(enter(M_START, 0));
            prev_tick = 1'b0;
        end else begin
            if (prev_tick) begin
                if (exp_q.size() == 0) chk("sb_depth", 32'(exp_q.size()), 32'd1);
                else cur = exp_q.pop_front();
            end
            chk("tick", 32'(tif.tick), 32'(tick_pend));
            chk("lamps", 32'(tif.lamps), 32'(cur.lamps));
            chk("phase", 32'(tif.phase), 32'(cur.phase));
            chk("remain", 32'(tif.remain), 32'(cur.remain));
            prev_tick = tif.tick;
            if (done_req) begin
                chk("sb_left", 32'(exp_q.size()), 32'd0);
                chk("wait_bound", 32'(to_cnt), 32'd0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    task automatic wait_for(input mst_t st, input int ph, input int left);
        int n;
        n = 0;
        while (!(m.st == st && (ph < 0 || m.phase == ph) && (left < 0 || m.left == left)) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) to_cnt = to_cnt + 1;
    endtask

    initial begin
        tif.en = 1'b1; tif.req = 4'b0000; tif.night = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (120) @(negedge clk);

        wait_for(M_GREEN, 0, -1);
        tif.req = 4'b1000;
        repeat (40) @(negedge clk);
        tif.req = 4'b0001;
        repeat (60) @(negedge clk);
        tif.req = 4'b0000;

        wait_for(M_GREEN, 2, GREEN_S - 1);
        tif.night = 1'b1;
        repeat (60) @(negedge clk);
        tif.night = 1'b0;
        repeat (60) @(negedge clk);

        wait_for(M_YEL, -1, -1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        repeat (100) @(negedge clk);

        wait_for(M_GREEN, -1, -1);
        tif.en = 1'b0;
        repeat (10) @(negedge clk);
        tif.en = 1'b1;
        repeat (50) @(negedge clk);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) tif.req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) tif.night = ~tif.night;
            tif.en = ($urandom_range(0, 9) != 0);
        end
        tif.night = 1'b0;
        tif.en = 1'b1;
        repeat (40) @(negedge clk);
        done_req = 1'b1;
        repeat (50) @(negedge clk);
        $display("FAIL final: summary not reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "bench did not terminate normally");
    end

endmodule

// File: doc/traffic_junction_ctrl.md
# traffic_junction_ctrl

Parametrised N-way junction signal controller: a one-second tick prescaler drives a phase sequencer that gives each approach, in turn, a green, yellow and all-red interval. Durations are configurable, and idle approaches are skipped on demand. A night mode flashes yellow on all approaches. It sits between the board clock and the lamp drivers, and exports the active phase and seconds-remaining for the seven-segment display path.

## Interface
- N_DIR, 4: number of approaches; ≥2
- TICK_DIV, 50_000_000: clk cycles per tick; ≥2
- CNT_W, 4: width of `remain`
- STARTUP_S, 2: startup all-red duration in ticks
- GREEN_S, 6: green duration in ticks
- YELLOW_S, 3: yellow duration in ticks
- ALLRED_S, 1: all-red clearance duration in ticks
- Duration rule: every `*_S` must be ≥1 and ≤2**CNT_W; an elaboration-time check fails otherwise.

- clk  in  1  board clock; one clock domain
- rst_n  in  1  reset, asynchronous assert, active-low
- en  in  1  1: run; 0: prescaler and sequencer hold their state
- req  in  N_DIR  per-approach demand (vehicle or pedestrian), level-sensitive, synchronous to clk
- night  in  1  night/flash mode request
- lamps  out  3*N_DIR  approach i occupies bits [3i+2:3i], encoded {R,Y,G}
- phase  out  clog2(N_DIR)  approach currently owning green/yellow
- remain  out  CNT_W  ticks remaining in the current interval, minus one
- tick  out  1  one-clk pulse each prescaler wrap

## Operation
- Lamp codes: RED=3'b100, YELLOW=3'b010, GREEN=3'b001, OFF=3'b000.
- States: STARTUP, GREEN, YELLOW, ALLRED, FLASH.
- STARTUP: all lamps RED for STARTUP_S ticks, then GREEN with phase 0.
- GREEN: `lamps[phase]`=GREEN and all other approaches RED for GREEN_S ticks, then YELLOW.
- YELLOW: `lamps[phase]`=YELLOW and all others RED for YELLOW_S ticks, then ALLRED.
- ALLRED: all approaches RED for ALLRED_S ticks. The next state is FLASH if `night`=1; otherwise GREEN with the next phase.
- Next-phase rule, evaluated at the ALLRED exit tick:
  - Search cyclically from phase+1 through phase+N_DIR-1 for the first approach with `req` set.
  - If there is no hit, use phase+1 mod N_DIR; round-robin is the default.
  - The current phase is selected again only if it is the sole requester.
- Night mode:
  - If `night`=1 is seen at a tick while in GREEN, the next state is YELLOW, which cuts green short.
  - FLASH: all approaches show YELLOW on even ticks and OFF on odd ticks; the first FLASH tick shows YELLOW.
  - If `night`=0 is seen at a tick while in FLASH, the next state is ALLRED with a full ALLRED_S, followed by the normal next-phase rule.
- Interval counter:
  - On entering a state, `remain` loads DUR-1.
  - Each tick decrements `remain`; a tick seen with `remain`=0 performs the transition.
  - Every interval therefore lasts exactly DUR ticks.
  - In FLASH, `remain` holds 0.
- `phase` changes only on entry to GREEN.

## Timing
- Prescaler counts 0..TICK_DIV-1. `tick` is high in the cycle the count equals TICK_DIV-1. The first tick occurs TICK_DIV cycles after rst_n deasserts.
- State, `lamps`, `phase` and `remain` are registered and update on the clk edge at which `tick`=1; this is one-cycle latency from the tick condition.
- `req` and `night` are sampled only on tick edges. Pulses between ticks are ignored, so a request must be held until it is served.
- `night` asserted at the ALLRED exit tick: FLASH takes priority over the next-phase rule.
- `en`=0: the prescaler count, `tick` (forced 0) and all state freeze. Resuming continues mid-interval with no lost or extra tick.
- Reset values, applied asynchronously on rst_n low:
  - state=STARTUP, lamps all RED, phase=0, remain=STARTUP_S-1
  - prescaler=0, tick=0
- Reset in any state, including mid-YELLOW, forces all RED immediately.
- No combinational path from inputs to outputs.

## Structure
- Package `traffic_pkg` holds:
  - lamp code constants RED, YELLOW, GREEN, OFF
  - state enum typedef: STARTUP, GREEN, YELLOW, ALLRED, FLASH
- Sub-module `tick_gen` (parameter TICK_DIV; ports clk, rst_n, en, tick) holds the prescaler.
- Sequencer, next-phase search and lamp decode stay in the top module.

## Test plan
All scenarios use N_DIR=4, TICK_DIV=4, STARTUP_S=2, GREEN_S=3, YELLOW_S=2, ALLRED_S=1, CNT_W=4.

- Release reset with req=0, night=0:
  - all RED for 8 clk cycles
  - phase 0 GREEN for 12 cycles (remain 2,1,0)
  - YELLOW for 8 cycles, ALLRED for 4 cycles
  - then phase 1 GREEN; full rotation 0→1→2→3→0
- req=4'b1000 held during phase 0 GREEN → after ALLRED, phase=3 GREEN (1 and 2 skipped). With req=4'b0001 only, phase 0 is selected again.
- night=1 at the second tick of phase 2 GREEN:
  - next tick: YELLOW on approach 2 for 2 ticks, then ALLRED for 1 tick
  - then FLASH: lamps=12'b010010010010 and 12'b0 alternating per tick
- night=0 during FLASH → ALLRED for 1 tick, then GREEN on phase+1 from the pre-flash phase (3), subject to req.
- rst_n pulsed low mid-YELLOW (asynchronous, between clk edges) → lamps all RED before the next clk edge; remain=1, phase=0; the STARTUP sequence restarts.
- en=0 for 10 cycles mid-GREEN → tick=0; lamps, remain and prescaler unchanged. After en=1, the GREEN interval completes with its original remaining length.
